// File: rtl/shift_unit_seq_if.sv
// shift_unit_seq_if: start/busy/done handshake and data bus of the iterative shifter
interface shift_unit_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    modport master (output start, op, operand, shamt, input busy, done, result);
    modport slave (input start, op, operand, shamt, output busy, done, result);
endinterface

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle SLL/SRL/SRA shifter moving STEP bits per clock; rotate-right built only with SHIFT_ROTATE_EN
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input logic clk,
    input logic reset,
    shift_unit_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
    localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       mode;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   rem;
    logic [SHW-1:0]   d;
    logic [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0] right_v;
    logic [WIDTH-1:0] nxt;

    // one step: d = min(STEP, rem); rem never exceeds WIDTH-1, so d always fits SHW bits
    always_comb begin
        d = ({1'b0, rem} < STEP_W) ? rem : STEP_W[SHW-1:0];
        sra_v = $signed(acc) >>> d;
`ifdef SHIFT_ROTATE_EN
        right_v = (mode == 2'b11) ? ((acc >> d) | (acc << (WIDTH_W - {1'b0, d}))) : (acc >> d);
`else
        right_v = acc >> d;
`endif
        nxt = (mode == 2'b00) ? (acc << d) : (mode == 2'b10) ? sra_v : right_v;
    end

    // sequencer: accept in IDLE/DONE, iterate in SHIFT until rem drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mode  <= 2'b00;
            acc   <= '0;
            rem   <= '0;
        end else if (state == SHIFT) begin
            acc <= nxt;
            rem <= rem - d;
            if (rem == d) state <= DONE;
        end else if (bus.start) begin
            acc   <= bus.operand;
            rem   <= bus.shamt;
            mode  <= bus.op;
            state <= SHIFT;
        end else begin
            state <= IDLE;
        end
    end

    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.result = acc;
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: scoreboard bench for shift_unit_seq (WIDTH=32, STEP=4)
module tb_shift_unit_seq;
    logic clk;
    logic reset;
    int checks;
    int failures;
    logic [31:0] q[$];
    int lq[$];

    shift_unit_seq_if #(.WIDTH(32)) bus ();
    shift_unit_seq #(.WIDTH(32), .STEP(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        logic signed [31:0] sa;
        logic [31:0] r;
        sa = a;
        if (o == 2'b00) r = a << s;
        else if (o == 2'b10) r = sa >>> s;
`ifdef SHIFT_ROTATE_EN
        else if (o == 2'b11) r = (s == 0) ? a : ((a >> s) | (a << (6'd32 - {1'b0, s})));
`endif
        else r = a >> s;
        return r;
    endfunction

    function automatic int lat(input logic [4:0] s);
        return (s == 0) ? 1 : (int'(s) + 3) / 4;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        bus.start = 1;
        bus.op = o;
        bus.operand = a;
        bus.shamt = s;
        q.push_back(model(o, a, s));
        lq.push_back(lat(s));
        @(negedge clk);
        bus.start = 0;
        bus.op = 2'($urandom);
        bus.operand = $urandom;
        bus.shamt = 5'($urandom);
    endtask

    task automatic wait_done(input bit poke, output int bc, output bit to);
        int n;
        bc = 0;
        to = 0;
        n = 0;
        while (!bus.done) begin
            if (n > 200) begin
                to = 1;
                break;
            end
            if (bus.busy) bc++;
            if (poke && bc == 2) begin
                bus.start = 1;
                bus.operand = 32'd5;
            end else begin
                bus.start = 0;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_op(input string name, input bit poke);
        int bc;
        bit to;
        logic [31:0] er;
        int el;
        wait_done(poke, bc, to);
        er = q.pop_front();
        el = lq.pop_front();
        checks++;
        if (to) begin
            failures++;
            $display("FAIL %s_timeout: done not seen within 200 cycles", name);
        end
        checks++;
        if (bus.result !== er) begin
            failures++;
            $display("FAIL %s_result: got %h expected %h", name, bus.result, er);
        end
        checks++;
        if (bc !== el) begin
            failures++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bc, el);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h expected 0 0 0", bus.busy, bus.done, bus.result);
        end
    endtask

    task automatic test_sra;
        issue(2'b10, 32'd52, 5'd2);
        finish_op("sra_52", 0);
        checks++;
        if (bus.result !== 32'd13) begin
            failures++;
            $display("FAIL sra_52_const: got %h expected %h", bus.result, 32'd13);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: done=%b expected 0", bus.done);
        end
        issue(2'b10, 32'hFFFFFF30, 5'd2);
        finish_op("sra_neg", 0);
        @(negedge clk);
        issue(2'b01, 32'hFFFFFF30, 5'd2);
        finish_op("srl_neg", 0);
        checks++;
        if (bus.result !== 32'h3FFFFFCC) begin
            failures++;
            $display("FAIL srl_neg_const: got %h expected %h", bus.result, 32'h3FFFFFCC);
        end
        @(negedge clk);
    endtask

    task automatic test_long_ignore;
        issue(2'b00, 32'h1, 5'd31);
        finish_op("sll_31", 1);
        checks++;
        if (bus.result !== 32'h80000000) begin
            failures++;
            $display("FAIL sll_31_const: got %h expected %h", bus.result, 32'h80000000);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        for (int o = 0; o < 4; o++) begin
            issue(2'(o), 32'hDEADBEEF, 5'd0);
            finish_op("shamt0", 0);
        end
        issue(2'b01, 32'hDEADBEEF, 5'd0);
        finish_op("b2b_first", 0);
        issue(2'b00, 32'h00000003, 5'd5);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_no_gap: busy=%b expected 1", bus.busy);
        end
        finish_op("b2b_second", 0);
        @(negedge clk);
    endtask

    task automatic test_abort;
        bit bad;
        issue(2'b00, 32'h12345678, 5'd20);
        void'(q.pop_front());
        void'(lq.pop_front());
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            failures++;
            $display("FAIL abort_async: busy=%b done=%b result=%h expected 0 0 0", bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        reset = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL abort_quiet: activity after reset release, busy=%b done=%b result=%h expected idle", bus.busy, bus.done, bus.result);
        end
    endtask

    task automatic test_rotate;
        issue(2'b11, 32'h0000000F, 5'd4);
        finish_op("ror_f", 0);
`ifdef SHIFT_ROTATE_EN
        checks++;
        if (bus.result !== 32'hF0000000) begin
            failures++;
            $display("FAIL ror_f_const: got %h expected %h", bus.result, 32'hF0000000);
        end
`else
        checks++;
        if (bus.result !== 32'h00000000) begin
            failures++;
            $display("FAIL ror_f_const: got %h expected %h", bus.result, 32'h00000000);
        end
`endif
        @(negedge clk);
        issue(2'b11, 32'h80000001, 5'd13);
        finish_op("ror_13", 0);
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            finish_op("random", 0);
            if (i % 2 == 0) @(negedge clk);
        end
    endtask

    initial begin
        clk = 0;
        reset = 1;
        checks = 0;
        failures = 0;
        bus.start = 0;
        bus.op = 2'b00;
        bus.operand = '0;
        bus.shamt = '0;
        repeat (2) @(negedge clk);
        test_reset;
        reset = 0;
        @(negedge clk);
        test_reset;
        test_sra;
        test_long_ignore;
        test_back_to_back;
        test_rotate;
        test_random;
        test_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
